tx_arbiter: RTL and testbench
=============================

Name: tx_arbiter

Overview:
Round-robin arbiter that shares the single `cereal` serial transmitter between N_REQ byte sources, for example a wordboard ROM walker, a status reporter and a debug echo.
- Accepts one byte per grant and drives `cereal`'s start/data pair.
- Tracks `cereal`'s status line to detect end of frame.
- Enforces an optional inter-frame gap.
- Replaces fixed-rate character pacing (clockdiv pulse) with status-driven flow control.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 0, idle sysclk cycles inserted after each frame before the next grant (0..65535).
- BUSY_TIMEOUT, 16, max cycles to wait for status to assert after tx_start; expiry aborts the frame.

Ports:
- sysclk  in  1  system clock.
- rst  in  1  synchronous reset, active-high (sampled on posedge sysclk).
- req  in  N_REQ  per-requester request; level, held until granted.
- req_data  in  8*N_REQ  byte for requester i in bits [8i+7:8i]; stable while req[i]=1.
- grant  out  N_REQ  one-hot, one-cycle pulse: byte of that requester accepted.
- tx_data  out  8  byte to `cereal`; held stable from launch until frame end.
- tx_start  out  1  one-cycle start pulse to `cereal`.
- tx_status  in  1  `cereal` status; 1 while a frame is being shifted out.
- busy  out  1  1 whenever state is not IDLE.
- timeout_err  out  1  sticky; set when BUSY_TIMEOUT expires; cleared only by rst.

Behaviour:
- Reset values: grant=0, tx_data=8'h00, tx_start=0, busy=0, timeout_err=0. Round-robin pointer = 0. State = IDLE. Reset mid-frame abandons the frame immediately with no further tx_start.
- Arbitration:
  - Search starts at pointer `ptr`. The first i with req[i]=1, scanning ptr, ptr+1, ... modulo N_REQ, wins.
  - After the grant, ptr <= winner+1, wrapping modulo N_REQ.
  - Requests that assert or change in the same cycle as an arbitration decision are evaluated from the values sampled in that cycle.
- State machine, one transition per posedge:
  - IDLE: if any req, then winner is latched, tx_data <= winner's byte, grant[winner] pulses for 1 cycle, and the next state is LAUNCH. Otherwise stay in IDLE.
  - LAUNCH: tx_start=1 for exactly this cycle; the timeout counter clears; the next state is WAIT_BUSY.
  - WAIT_BUSY:
    - If tx_status=1, go to WAIT_DONE.
    - Else if the counter reaches BUSY_TIMEOUT-1, set timeout_err and go to GAP.
    - Else increment the counter.
  - WAIT_DONE: stay while tx_status=1. When tx_status=0, go to GAP, or to IDLE if GAP_CYCLES=0.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- Latency: req asserted with the arbiter in IDLE gives grant 1 cycle later and tx_start 2 cycles later.
- Minimum spacing between consecutive tx_start pulses is 4 + GAP_CYCLES + frame length.
- tx_data changes only on an IDLE->LAUNCH transition.
- A requester dropping req before its grant is not an error; it is simply not served.
- If tx_status is already 1 on entry to WAIT_BUSY (a stale frame), the arbiter treats it as the new frame's busy.
- A single requester with continuous req is served back-to-back; no starvation is possible with round-robin.
- Counters are sized to $clog2 of the maximum of the parameter value and 2. The GAP counter is 16 bits.

Decomposition:
- Shared package `tx_pkg`: state enum (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP) and the 8-bit byte width constant.
- One sub-module, `rr_pick`: combinational round-robin priority select (req, ptr -> one-hot winner plus valid). It is reusable by future shared-resource blocks.

Test Plan:
1. Reset mid-WAIT_DONE (rst=1 for 1 cycle) -> next cycle all outputs at reset values; no tx_start until a new req.
2. req=4'b0001, req_data[7:0]=8'h41, model status high for 10 cycles after start -> grant=0001 at cycle 1; tx_start at cycle 2; tx_data=8'h41 through the frame; busy=0 after status falls.
3. req=4'b1111 held, four distinct bytes -> grants in order 0001, 0010, 0100, 1000, 0001; exactly one tx_start per grant; byte order matches.
4. req=4'b1010 with ptr=2 after reset, via a prior grant of requester 1 -> requester 3 granted before requester 1.
5. tx_status tied 0, BUSY_TIMEOUT=16 -> timeout_err=1 exactly 16 cycles after tx_start; arbiter returns to IDLE and serves the next req.
6. GAP_CYCLES=5, two back-to-back requests -> at least 5 idle cycles between status falling and the second grant.

Source files
------------

// File: rtl/tx_pkg.sv
// Purpose: shared state encoding and byte width for the transmit arbiter family.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package tx_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } tx_state_t;

endpackage

// File: rtl/rr_pick.sv
// Purpose: round-robin priority select; first set req at or after ptr (mod N) wins.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on vld/gnt.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx,
  output logic             vld
);

  localparam int SW = PTR_W + 1;

  logic [SW-1:0]    sum;
  logic [PTR_W-1:0] pos;

  // Scan offsets from farthest to nearest so the position closest to ptr is the last hit and wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    sum = '0;
    pos = '0;
    vld = |req;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(N)) begin
        sum = sum - SW'(N);
      end
      pos = sum[PTR_W-1:0];
      if (req[pos]) begin
        idx = pos;
      end
    end
    if (vld) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Purpose: round-robin share of one serial transmitter between N_REQ byte sources.
// Latency: req seen in IDLE -> grant next cycle -> tx_start the cycle after that.
// Backpressure: requesters hold req until granted; next grant waits for tx_status to fall plus GAP_CYCLES.
module tx_arbiter
  import tx_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int GAP_CYCLES   = 0,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                    sysclk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        grant,
  output logic [BYTE_W-1:0]       tx_data,
  output logic                    tx_start,
  input  logic                    tx_status,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int TO_W  = $clog2((BUSY_TIMEOUT > 2) ? BUSY_TIMEOUT : 2);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TIMEOUT - 1);
  localparam logic [15:0]      GAP_LAST = 16'(GAP_CYCLES - 1);

  tx_state_t         state_q;
  tx_state_t         state_d;
  logic [PTR_W-1:0]  ptr_q;
  logic [TO_W-1:0]   to_cnt;
  logic [15:0]       gap_cnt;
  logic [N_REQ-1:0]  pick_gnt;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_vld;
  logic              to_hit;
  logic              gap_done;
  logic [BYTE_W-1:0] req_bytes [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_bytes[g] = req_data[g*BYTE_W +: BYTE_W];
  end

  rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  // A timeout with no gap configured still spends one cycle in GAP before returning to IDLE.
  assign gap_done = (GAP_CYCLES <= 1) || (gap_cnt == GAP_LAST);
  assign busy     = (state_q != IDLE);

  // State register.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; to_hit flags the cycle in which the busy wait gives up.
  always_comb begin
    state_d = state_q;
    to_hit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_status) begin
          state_d = WAIT_DONE;
        end else if (to_cnt == TO_LAST) begin
          state_d = GAP;
          to_hit  = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_status) begin
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs and counters; tx_start is the registered image of LAUNCH, so it
  // appears together with the first WAIT_BUSY cycle and the timeout counts from the pulse.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      grant       <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      ptr_q       <= '0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
    end else begin
      grant    <= '0;
      tx_start <= (state_q == LAUNCH);
      if (state_q == IDLE && pick_vld) begin
        grant   <= pick_gnt;
        tx_data <= req_bytes[pick_idx];
        ptr_q   <= (pick_idx == PTR_LAST) ? '0 : pick_idx + 1'b1;
      end
      if (state_q == LAUNCH) begin
        to_cnt <= '0;
      end else if (state_q == WAIT_BUSY && !tx_status && !to_hit) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (to_hit) begin
        timeout_err <= 1'b1;
      end
      if (state_q == GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Purpose: randomized scoreboard bench for tx_arbiter with a transaction-level reference.
// Latency: model predicts grant at decision+1, tx_start at decision+2.
// Backpressure: a cereal model drives tx_status for a planned frame length after each tx_start.
module tb_tx_arbiter;

  localparam int N   = 4;
  localparam int GAP = 5;
  localparam int BTO = 16;
  localparam int INF = 32'h7fffffff;

  logic         sysclk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [8*N-1:0] req_data;
  logic [N-1:0] grant;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         tx_status;
  logic         busy;
  logic         timeout_err;

  tx_arbiter #(
    .N_REQ        (N),
    .GAP_CYCLES   (GAP),
    .BUSY_TIMEOUT (BTO)
  ) dut (
    .sysclk      (sysclk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .grant       (grant),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_status   (tx_status),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [N-1:0] oh;
    logic [7:0]   b;
  } ev_t;

  ev_t gq[$];
  ev_t sq[$];
  int  len_q[$];
  ev_t mg;
  ev_t ms;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  logic       exp_busy_now = 1'b0;
  logic [7:0] exp_txd_now  = 8'h00;
  logic       exp_err_now  = 1'b0;

  // reference model state
  int           ptr     = 0;
  int           free_at = 0;
  int           err_cyc = INF;
  logic [7:0]   mdl_txd = 8'h00;
  logic [N-1:0] pend    = '0;
  logic [7:0]   bytes  [N];
  int           clr_at [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // One stimulus cycle: update requesters, publish expectations for this cycle, then arbitrate.
  task automatic step(input logic [N-1:0] raise, input int len_sel, input int byte_sel,
                      input bit do_rst, input bit allow_drop);
    int t;
    int w;
    int L;
    ev_t e;
    @(posedge sysclk);
    #1;
    t = cyc;
    for (int i = 0; i < N; i++) begin
      if (pend[i] && clr_at[i] == t) begin
        pend[i]   = 1'b0;
        clr_at[i] = -1;
      end
      if (allow_drop && pend[i] && clr_at[i] < 0 && $urandom_range(0, 63) == 0) pend[i] = 1'b0;
      if (raise[i] && !pend[i]) begin
        pend[i]  = 1'b1;
        bytes[i] = (byte_sel >= 0) ? 8'(byte_sel) : 8'($urandom);
      end
    end
    if (do_rst) begin
      pend = '0;
      for (int i = 0; i < N; i++) clr_at[i] = -1;
    end
    rst = do_rst;
    req = pend;
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = bytes[i];
    exp_busy_now = (t < free_at);
    exp_txd_now  = mdl_txd;
    exp_err_now  = (t >= err_cyc);
    if (do_rst) begin
      ptr     = 0;
      free_at = t + 1;
      err_cyc = INF;
      mdl_txd = 8'h00;
      gq.delete();
      sq.delete();
      len_q.delete();
    end else if (t >= free_at && pend != '0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && pend[(ptr + k) % N]) w = (ptr + k) % N;
      end
      if (len_sel >= 0) L = len_sel;
      else L = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 8));
      e.cyc = t + 1; e.oh = N'(1) << w; e.b = bytes[w];
      gq.push_back(e);
      e.cyc = t + 2; e.oh = '0;
      sq.push_back(e);
      len_q.push_back(L);
      mdl_txd   = bytes[w];
      ptr       = (w + 1) % N;
      clr_at[w] = t + 2;
      if (L > 0) begin
        free_at = t + 2 + L + 2 + GAP;
      end else begin
        free_at = t + 2 + BTO + ((GAP > 0) ? GAP : 1);
        if (err_cyc == INF) err_cyc = t + 2 + BTO;
      end
    end
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 400; k++) begin
      if (pend == '0 && cyc + 1 >= free_at && gq.size() == 0 && sq.size() == 0) break;
      step('0, -1, -1, 1'b0, 1'b0);
    end
    total++;
    if (k >= 400) begin
      bad++;
      $display("FAIL drain_budget cyc=%0d got=%0d cycles want=<400", cyc, k);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge sysclk);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  // Monitor: per-cycle level checks plus scoreboard pops for grant and tx_start events.
  always @(negedge sysclk) begin
    if (mon_en) begin
      chk("busy", busy, exp_busy_now);
      chk("tx_data", tx_data, exp_txd_now);
      chk("timeout_err", timeout_err, exp_err_now);
      if (gq.size() > 0 && gq[0].cyc <= cyc) begin
        mg = gq.pop_front();
        chk("grant", grant, mg.oh);
      end else if (grant !== '0) begin
        chk("grant_unexpected", grant, 0);
      end
      if (sq.size() > 0 && sq[0].cyc <= cyc) begin
        ms = sq.pop_front();
        chk("tx_start", tx_start, 1);
        chk("start_data", tx_data, ms.b);
      end else if (tx_start !== 1'b0) begin
        chk("start_unexpected", tx_start, 0);
      end
    end
  end

  // Cereal model: after each tx_start, hold tx_status high for the planned frame length.
  initial begin
    int L;
    tx_status = 1'b0;
    forever begin
      @(negedge sysclk);
      if (mon_en && tx_start === 1'b1) begin
        L = (len_q.size() > 0) ? len_q.pop_front() : 0;
        if (L > 0) begin
          @(posedge sysclk);
          #1 tx_status = 1'b1;
          repeat (L) @(posedge sysclk);
          #1 tx_status = 1'b0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] m;
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      clr_at[i] = -1;
      bytes[i]  = 8'h00;
    end
    repeat (3) step('0, -1, -1, 1'b1, 1'b0);
    step('0, -1, -1, 1'b0, 1'b0);
    mon_en = 1'b1;
    check_reset_vals("por");

    // all four requesters held: strict rotation 0,1,2,3,0,...
    for (int k = 0; k < 80; k++) step('1, 3, -1, 1'b0, 1'b0);
    drain();

    // single requester, 10-cycle frame, fixed byte
    step(4'b0001, 10, 8'h41, 1'b0, 1'b0);
    drain();

    // status never rises: busy wait times out
    step(4'b0001, 0, -1, 1'b0, 1'b0);
    drain();
    step(4'b0100, 2, -1, 1'b0, 1'b0);
    drain();

    // randomized traffic with occasional request withdrawal and timeouts
    for (int k = 0; k < 2500; k++) begin
      for (int i = 0; i < N; i++) m[i] = ($urandom_range(0, 5) == 0);
      step(m, -1, -1, 1'b0, 1'b1);
    end
    drain();

    // reset while the frame is in WAIT_DONE
    step(4'b0001, 10, -1, 1'b0, 1'b0);
    repeat (7) step('0, -1, -1, 1'b0, 1'b0);
    step('0, -1, -1, 1'b1, 1'b0);
    step('0, -1, -1, 1'b0, 1'b0);
    check_reset_vals("midrst");
    repeat (10) step('0, -1, -1, 1'b0, 1'b0);

    // grant requester 1 to move the pointer to 2, then 3 must win over 1
    step(4'b0010, 2, -1, 1'b0, 1'b0);
    drain();
    step(4'b1010, 2, -1, 1'b0, 1'b0);
    drain();
    repeat (3) step('0, -1, -1, 1'b0, 1'b0);

    chk("grant_queue_left", gq.size(), 0);
    chk("start_queue_left", sq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
